// File: rtl/rst_sequencer.sv
// rst_sequencer: waits for a stable synchronized lock, then releases per-bank
// synchronous resets one at a time; any lock loss or SW_RST reasserts them all at once.
module rst_sequencer #(
  parameter int NSTAGE      = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK,
  input  logic              SW_RST,
  output logic [NSTAGE-1:0] RST_OUT,
  output logic              READY,
  output logic [CNT_W-1:0]  LOSS_CNT
);
  localparam int CMAX = LOCK_CYCLES > STAGE_GAP ? LOCK_CYCLES : STAGE_GAP;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int IW   = NSTAGE > 1 ? $clog2(NSTAGE) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSTAGE - 1);
  typedef enum logic [1:0] {HOLD, LOCK_WAIT, RELEASE, RUN} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NSTAGE-1:0]      rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic                   lock_s, hold;
  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign hold     = !lock_s || SW_RST;
  assign RST_OUT  = rst_q;
  assign READY    = ready_q;
  assign LOSS_CNT = loss_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], LOCK};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    if (hold) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      // only a real lock loss counts, and only once the sequence had started
      if (state_q != HOLD && !lock_s && loss_q != '1) loss_d = loss_q + 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
        end
        LOCK_WAIT: begin
          cnt_d = cnt_q == LOCK_LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == LOCK_LAST) begin
            rst_d[0] = 1'b0;
            idx_d    = IW'(1);
            state_d  = NSTAGE == 1 ? RUN : RELEASE;
            ready_d  = NSTAGE == 1;
          end
        end
        RELEASE: begin
          cnt_d = cnt_q == GAP_LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) begin
            rst_d[idx_q] = 1'b0;
            idx_d        = idx_q + 1'b1;
            state_d      = idx_q == IDX_LAST ? RUN : RELEASE;
            ready_d      = idx_q == IDX_LAST;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
